// File: rtl/seq_alu.sv
// Clocked WIDTH-bit ALU with a start/busy/done handshake. ADD/SUB/logic/shift
// and illegal opcodes finish in one cycle; MUL/DIV/MOD iterate once per bit.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;

  // Single-cycle datapath, driven straight from the ports at the accepting edge.
  logic [WIDTH:0]   add_full, sub_full, shl_full, shr_full;
  logic [SW-1:0]    sh_amt;
  logic [WIDTH-1:0] sc_y;
  logic             sc_c, sc_v, sc_err, is_multi;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    sh_amt   = B[SW-1:0];
    add_full = {1'b0, A} + {1'b0, B};
    sub_full = {1'b0, A} - {1'b0, B};
    shl_full = {1'b0, A} << sh_amt;
    shr_full = {A, 1'b0} >> sh_amt;
    is_multi = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    sc_y     = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_err   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_y = add_full[MSB:0];
        sc_c = add_full[WIDTH];
        sc_v = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
      end
      OP_SUB: begin
        sc_y = sub_full[MSB:0];
        sc_c = sub_full[WIDTH];
        sc_v = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);
      end
      OP_AND: sc_y = A & B;
      OP_OR:  sc_y = A | B;
      OP_XOR: sc_y = A ^ B;
      OP_SHL: begin
        sc_y = shl_full[MSB:0];
        sc_c = shl_full[WIDTH];
      end
      OP_SHR: begin
        sc_y = shr_full[WIDTH:1];
        sc_c = shr_full[0];
      end
      OP_MUL, OP_DIV, OP_MOD: sc_err = 1'b0;
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration step: hi/lo hold the product halves for MUL and the
  // remainder/quotient pair for DIV/MOD.
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[MSB:1]};
    div_shift = {hi_q, lo_q[MSB]};
    div_trial = div_shift - {1'b0, b_q};
    div_ge    = ~div_trial[WIDTH];
    div_hi    = div_ge ? div_trial[MSB:0] : div_shift[MSB:0];
    div_lo    = {lo_q[MSB-1:0], div_ge};
  end

  logic             load;
  logic [WIDTH-1:0] res_y;
  logic             res_c, res_v, res_err;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    res_y   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_d = op;
          a_d  = A;
          b_d  = B;
          if (is_multi) begin
            state_d = S_RUN;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = (op == OP_MUL) ? B : A;
          end else begin
            state_d = S_DONE;
            load    = 1'b1;
            res_y   = sc_y;
            res_c   = sc_c;
            res_v   = sc_v;
            res_err = sc_err;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        hi_d  = (op_q == OP_MUL) ? mul_hi : div_hi;
        lo_d  = (op_q == OP_MUL) ? mul_lo : div_lo;
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d = S_DONE;
          load    = 1'b1;
          case (op_q)
            OP_MUL: begin
              res_y = mul_lo;
              res_c = |mul_hi;
              res_v = |mul_hi;
            end
            OP_DIV: begin
              res_y   = (b_q == '0) ? '1 : div_lo;
              res_err = (b_q == '0);
            end
            default: begin
              res_y   = (b_q == '0) ? a_q : div_hi;
              res_err = (b_q == '0);
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    y_d   = y_q;
    n_d   = n_q;
    z_d   = z_q;
    c_d   = c_q;
    v_d   = v_q;
    err_d = err_q;
    if (load) begin
      y_d   = res_y;
      n_d   = res_y[MSB];
      z_d   = (res_y == '0);
      c_d   = res_c;
      v_d   = res_v;
      err_d = res_err;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign Y    = y_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign C    = c_q;
  assign V    = v_q;
  assign err  = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): vector table plus hand-written handshake,
// reset-abort and back-to-back sequences, checked through a scoreboard queue.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B;
  logic [3:0]   op;
  logic         busy, done, N, Z, C, V, err;
  logic [W-1:0] Y;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .op(op),
    .busy(busy), .done(done), .Y(Y), .N(N), .Z(Z), .C(C), .V(V), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [4:0]   f;    // {N,Z,C,V,err}
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] y;
    logic [4:0]   f;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("Y", 32'(Y), 32'(e.y));
        check("flags NZCVerr", 32'({N, Z, C, V, err}), 32'(e.f));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track, input logic [W-1:0] ey, input logic [4:0] ef,
                       input int lat);
    exp_t e;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    if (track) begin
      e.y = ey; e.f = ef; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[22];
    exp_t e;
    int   busy_cycles;
    int   snap;

    vecs = '{
      '{4'd0, 8'd100, 8'd50,  8'h96, 5'b10010, 1},
      '{4'd1, 8'd3,   8'd5,   8'hFE, 5'b10100, 1},
      '{4'd0, 8'hFF,  8'h01,  8'h00, 5'b01100, 1},
      '{4'd1, 8'h80,  8'h01,  8'h7F, 5'b00010, 1},
      '{4'd2, 8'd20,  8'd13,  8'h04, 5'b00110, 9},
      '{4'd2, 8'd15,  8'd17,  8'hFF, 5'b10000, 9},
      '{4'd3, 8'd200, 8'd7,   8'd28, 5'b00000, 9},
      '{4'd4, 8'd200, 8'd7,   8'd4,  5'b00000, 9},
      '{4'd3, 8'd8,   8'd0,   8'hFF, 5'b10001, 9},
      '{4'd4, 8'd8,   8'd0,   8'd8,  5'b00001, 9},
      '{4'd3, 8'd5,   8'd9,   8'h00, 5'b01000, 9},
      '{4'd8, 8'h81,  8'd1,   8'h02, 5'b00100, 1},
      '{4'd9, 8'h81,  8'd9,   8'h40, 5'b00100, 1},
      '{4'd7, 8'h5A,  8'h5A,  8'h00, 5'b01000, 1},
      '{4'd8, 8'h81,  8'd0,   8'h81, 5'b10000, 1},
      '{4'd9, 8'h81,  8'd7,   8'h01, 5'b00000, 1},
      '{4'd5, 8'hF0,  8'h3C,  8'h30, 5'b00000, 1},
      '{4'd6, 8'hF0,  8'h0F,  8'hFF, 5'b10000, 1},
      '{4'd12, 8'h33, 8'h44,  8'h00, 5'b01001, 1},
      '{4'd15, 8'hFF, 8'hFF,  8'h00, 5'b01001, 1},
      '{4'd4, 8'd255, 8'd16,  8'h0F, 5'b00000, 9},
      '{4'd2, 8'd255, 8'd255, 8'h01, 5'b00110, 9}
    };

    rst = 1'b1; start = 1'b0; A = '0; B = '0; op = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset Y", 32'(Y), 32'd0);
    check("reset flags", 32'({N, Z, C, V, err}), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].y, vecs[i].f, vecs[i].lat);
      wait_drain();
    end

    // MUL with operand change and an ignored start during busy.
    issue(4'd2, 8'd20, 8'd13, 1'b1, 8'h04, 5'b00110, 9);
    busy_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      if (i == 2) begin
        A = 8'd0; op = 4'd0; start = 1'b1;
      end
      if (i == 3) start = 1'b0;
    end
    check("MUL busy cycles", 32'(busy_cycles), 32'd8);
    wait_drain();
    repeat (3) @(negedge clk);

    // Reset in the middle of a MUL aborts it without a done.
    issue(4'd2, 8'd20, 8'd13, 1'b0, 8'h00, 5'b00000, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort Y", 32'(Y), 32'd0);
    check("abort flags", 32'({N, Z, C, V, err}), 32'd0);
    rst = 1'b0;
    snap = done_cnt;
    repeat (12) @(negedge clk);
    check("no done after abort", 32'(done_cnt - snap), 32'd0);

    // Back-to-back: start held high across DONE.
    @(negedge clk);
    op = 4'd0; A = 8'd1; B = 8'd2; start = 1'b1;
    e.y = 8'd3; e.f = 5'b00000; e.cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    op = 4'd5; A = 8'h0F; B = 8'h3C;
    e.y = 8'h0C; e.f = 5'b00000; e.cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
